// File: rtl/expr_sequencer.sv
// expr_sequencer: table-driven control sequencer for the expression-solver datapath.
// A writable table of STEPS control words is played one word per cycle on start,
// optionally repeated for several iterations, then the sequencer parks in DONE.
// Ports:
//   clk, rst (async active-low), start, abort, [step_en], iters,
//   prog_we/prog_addr/prog_data (table write), ctrl, step, busy, completed, prog_err.
// Optional feature macro: EXPR_SEQ_SINGLE_STEP_EN adds step_en, which gates advance in RUN.
module expr_sequencer #(
  parameter int unsigned CW_W    = 10,
  parameter int unsigned STEPS   = 6,
  parameter int unsigned STEP_AW = 3,
  parameter int unsigned ITER_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
`ifdef EXPR_SEQ_SINGLE_STEP_EN
  input  logic               step_en,
`endif
  input  logic [ITER_W-1:0]  iters,
  input  logic               prog_we,
  input  logic [STEP_AW-1:0] prog_addr,
  input  logic [CW_W-1:0]    prog_data,
  output logic [CW_W-1:0]    ctrl,
  output logic [STEP_AW-1:0] step,
  output logic               busy,
  output logic               completed,
  output logic               prog_err
);

  localparam int unsigned        DEPTH     = 2 ** STEP_AW;
  localparam logic [STEP_AW-1:0] LAST_STEP = STEP_AW'(STEPS - 1);
  localparam logic [STEP_AW:0]   STEPS_V   = (STEP_AW + 1)'(STEPS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, state_d;
  logic [CW_W-1:0]     tbl [DEPTH];
  logic [ITER_W-1:0]   iter_cnt, iter_cnt_d;
  logic [CW_W-1:0]     ctrl_d;
  logic [STEP_AW-1:0]  step_d;
  logic                busy_d, completed_d, prog_err_d;
  logic                wr_ok_c, adv_c;
  logic [CW_W-1:0]     word0_c;
  logic [STEP_AW-1:0]  step_nx_c;

  // Writes are only legal while not running and inside the active table.
  assign wr_ok_c    = prog_we && !busy && ({1'b0, prog_addr} < STEPS_V);
  assign prog_err_d = prog_we && !wr_ok_c;

  // A write to entry 0 on the start edge is forwarded so the run sees the new word.
  assign word0_c   = (wr_ok_c && (prog_addr == '0)) ? prog_data : tbl[0];
  assign step_nx_c = STEP_AW'(step + 1'b1);

`ifdef EXPR_SEQ_SINGLE_STEP_EN
  assign adv_c = step_en;
`else
  assign adv_c = 1'b1;
`endif

  // Control table storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) tbl[i] <= '0;
    end else if (wr_ok_c) begin
      tbl[prog_addr] <= prog_data;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      iter_cnt  <= '0;
      ctrl      <= '0;
      step      <= '0;
      busy      <= 1'b0;
      completed <= 1'b0;
      prog_err  <= 1'b0;
    end else begin
      state     <= state_d;
      iter_cnt  <= iter_cnt_d;
      ctrl      <= ctrl_d;
      step      <= step_d;
      busy      <= busy_d;
      completed <= completed_d;
      prog_err  <= prog_err_d;
    end
  end

  // Next-state and next-output logic; abort overrides everything.
  always_comb begin
    state_d     = state;
    iter_cnt_d  = iter_cnt;
    ctrl_d      = ctrl;
    step_d      = step;
    busy_d      = busy;
    completed_d = completed;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_d     = RUN;
          ctrl_d      = word0_c;
          step_d      = '0;
          busy_d      = 1'b1;
          completed_d = 1'b0;
          // iters of 0 behaves as a single pass.
          iter_cnt_d  = (iters == '0) ? '0 : ITER_W'(iters - 1'b1);
        end
      end
      RUN: begin
        if (adv_c) begin
          if (step == LAST_STEP) begin
            if (iter_cnt != '0) begin
              step_d     = '0;
              ctrl_d     = tbl[0];
              iter_cnt_d = ITER_W'(iter_cnt - 1'b1);
            end else begin
              state_d     = DONE;
              ctrl_d      = '0;
              step_d      = '0;
              busy_d      = 1'b0;
              completed_d = 1'b1;
            end
          end else begin
            step_d = step_nx_c;
            ctrl_d = tbl[step_nx_c];
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d     = IDLE;
      ctrl_d      = '0;
      step_d      = '0;
      busy_d      = 1'b0;
      completed_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_expr_sequencer.sv
// Testbench for expr_sequencer: randomized table programming and runs checked
// against a list-of-expected-words model built from the table contents and iters.
module tb_expr_sequencer;

  localparam int CW_W    = 10;
  localparam int STEPS   = 6;
  localparam int STEP_AW = 3;
  localparam int ITER_W  = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               start, abort, prog_we;
  logic [ITER_W-1:0]  iters;
  logic [STEP_AW-1:0] prog_addr;
  logic [CW_W-1:0]    prog_data;
  logic [CW_W-1:0]    ctrl;
  logic [STEP_AW-1:0] step;
  logic               busy, completed, prog_err;
`ifdef EXPR_SEQ_SINGLE_STEP_EN
  logic               step_en;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [CW_W-1:0] mdl [STEPS];

  always #5 clk = ~clk;

  expr_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
`ifdef EXPR_SEQ_SINGLE_STEP_EN
    .step_en   (step_en),
`endif
    .iters     (iters),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .ctrl      (ctrl),
    .step      (step),
    .busy      (busy),
    .completed (completed),
    .prog_err  (prog_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int addr, input logic [CW_W-1:0] data);
    prog_we   = 1'b1;
    prog_addr = STEP_AW'(addr);
    prog_data = data;
    tick();
    prog_we   = 1'b0;
  endtask

  // Starts a run and compares every word against the expected play-out list.
  task automatic run_check(input int it_val, input string name);
    logic [CW_W-1:0] exp_q [$];
    int              stp_q [$];
    int              n;
    n = (it_val == 0) ? 1 : it_val;
    for (int i = 0; i < n; i++)
      for (int s = 0; s < STEPS; s++) begin
        exp_q.push_back(mdl[s]);
        stp_q.push_back(s);
      end
    start = 1'b1;
    iters = ITER_W'(it_val);
    tick();
    start = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      n_tests++;
      if (ctrl !== exp_q[k] || step !== STEP_AW'(stp_q[k]) || busy !== 1'b1 || completed !== 1'b0) begin
        n_fail++;
        $display("FAIL %s word %0d: ctrl=%h step=%0d busy=%b completed=%b, required ctrl=%h step=%0d busy=1 completed=0",
                 name, k, ctrl, step, busy, completed, exp_q[k], stp_q[k]);
      end
      // start during RUN must be ignored; drop it before the DONE edge.
      start = (k < exp_q.size() - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
    end
    n_tests++;
    if (completed !== 1'b1 || ctrl !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s end: completed=%b ctrl=%h busy=%b, required completed=1 ctrl=0 busy=0",
               name, completed, ctrl, busy);
    end
  endtask

  task automatic test_reset();
    n_tests++;
    if (ctrl !== '0 || step !== '0 || busy !== 1'b0 || completed !== 1'b0 || prog_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: ctrl=%h step=%0d busy=%b completed=%b prog_err=%b, required all 0",
               ctrl, step, busy, completed, prog_err);
    end
  endtask

  task automatic test_program();
    logic [CW_W-1:0] words [STEPS];
    words = '{10'h3A0, 10'h208, 10'h112, 10'h021, 10'h3C5, 10'h00C};
    for (int i = 0; i < STEPS; i++) begin
      do_write(i, words[i]);
      mdl[i] = words[i];
      n_tests++;
      if (prog_err !== 1'b0) begin
        n_fail++;
        $display("FAIL program_ok addr %0d: prog_err=%b, required 0", i, prog_err);
      end
    end
    run_check(1, "program_iters1");
  endtask

  task automatic test_iters();
    run_check(3, "iters3");
    run_check(0, "iters0");
    run_check(15, "iters15");
  endtask

  task automatic test_write_start();
    logic [CW_W-1:0] d;
    d = CW_W'($urandom_range(1, 1023));
    prog_we = 1'b1; prog_addr = '0; prog_data = d;
    start = 1'b1; iters = ITER_W'(1);
    tick();
    prog_we = 1'b0; start = 1'b0;
    mdl[0] = d;
    n_tests++;
    if (ctrl !== d || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL write_start: ctrl=%h busy=%b, required ctrl=%h busy=1", ctrl, busy, d);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_prog_err();
    start = 1'b1; iters = ITER_W'(1);
    tick();
    start = 1'b0;
    do_write(1, ~mdl[1]);
    n_tests++;
    if (prog_err !== 1'b1 || ctrl !== mdl[1]) begin
      n_fail++;
      $display("FAIL prog_err_run: prog_err=%b ctrl=%h, required prog_err=1 ctrl=%h", prog_err, ctrl, mdl[1]);
    end
    tick();
    n_tests++;
    if (prog_err !== 1'b0 || ctrl !== mdl[2]) begin
      n_fail++;
      $display("FAIL prog_err_run_pulse: prog_err=%b ctrl=%h, required prog_err=0 ctrl=%h", prog_err, ctrl, mdl[2]);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    do_write(6, CW_W'($urandom));
    n_tests++;
    if (prog_err !== 1'b1) begin
      n_fail++;
      $display("FAIL prog_err_addr6: prog_err=%b, required 1", prog_err);
    end
    tick();
    n_tests++;
    if (prog_err !== 1'b0) begin
      n_fail++;
      $display("FAIL prog_err_addr6_pulse: prog_err=%b, required 0", prog_err);
    end
    run_check(1, "prog_err_unchanged");
  endtask

  task automatic test_abort();
    start = 1'b1; iters = ITER_W'(2);
    tick();
    start = 1'b0;
    tick();
    tick();
    n_tests++;
    if (step !== STEP_AW'(2) || ctrl !== mdl[2]) begin
      n_fail++;
      $display("FAIL abort_pre: step=%0d ctrl=%h, required step=2 ctrl=%h", step, ctrl, mdl[2]);
    end
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    n_tests++;
    if (ctrl !== '0 || busy !== 1'b0 || completed !== 1'b0) begin
      n_fail++;
      $display("FAIL abort: ctrl=%h busy=%b completed=%b, required all 0", ctrl, busy, completed);
    end
    tick();
    n_tests++;
    if (ctrl !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: ctrl=%h busy=%b, required 0 0", ctrl, busy);
    end
    run_check(1, "abort_replay");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_tests++;
    if (completed !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_done: completed=%b, required 0", completed);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      int nw;
      nw = $urandom_range(3, 8);
      for (int w = 0; w < nw; w++) begin
        int a;
        logic [CW_W-1:0] d;
        a = $urandom_range(0, 7);
        d = CW_W'($urandom);
        do_write(a, d);
        if (a < STEPS) mdl[a] = d;
        n_tests++;
        if (prog_err !== 1'(a >= STEPS)) begin
          n_fail++;
          $display("FAIL random_write r%0d addr %0d: prog_err=%b, required %b", r, a, prog_err, 1'(a >= STEPS));
        end
      end
      run_check($urandom_range(0, 15), "random_run");
    end
  endtask

  task automatic test_reset_mid_run();
    start = 1'b1; iters = ITER_W'(3);
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    n_tests++;
    if (step !== STEP_AW'(3) || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_pre: step=%0d busy=%b, required step=3 busy=1", step, busy);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (ctrl !== '0 || busy !== 1'b0 || completed !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: ctrl=%h busy=%b completed=%b, required all 0", ctrl, busy, completed);
    end
    tick();
    rst = 1'b1;
    for (int i = 0; i < STEPS; i++) mdl[i] = '0;
    run_check(1, "reset_table_cleared");
  endtask

`ifdef EXPR_SEQ_SINGLE_STEP_EN
  task automatic test_single_step();
    for (int i = 0; i < STEPS; i++) begin
      mdl[i] = CW_W'($urandom);
      do_write(i, mdl[i]);
    end
    step_en = 1'b0;
    start = 1'b1; iters = ITER_W'(1);
    tick();
    start = 1'b0;
    for (int k = 0; k < STEPS; k++)
      for (int c = 0; c < 3; c++) begin
        n_tests++;
        if (ctrl !== mdl[k] || step !== STEP_AW'(k) || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL single_step word %0d cyc %0d: ctrl=%h step=%0d busy=%b, required ctrl=%h step=%0d busy=1",
                   k, c, ctrl, step, busy, mdl[k], k);
        end
        step_en = (c == 2);
        tick();
      end
    step_en = 1'b1;
    n_tests++;
    if (completed !== 1'b1 || ctrl !== '0) begin
      n_fail++;
      $display("FAIL single_step_end: completed=%b ctrl=%h, required 1 0", completed, ctrl);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; prog_we = 1'b0;
    iters = '0; prog_addr = '0; prog_data = '0;
`ifdef EXPR_SEQ_SINGLE_STEP_EN
    step_en = 1'b1;
`endif
    for (int i = 0; i < STEPS; i++) mdl[i] = '0;
    #3 rst = 1'b0;
    #4;
    test_reset();
    tick();
    rst = 1'b1;
    tick();
    test_program();
    test_iters();
    test_write_start();
    test_prog_err();
    test_abort();
    test_random();
    test_reset_mid_run();
`ifdef EXPR_SEQ_SINGLE_STEP_EN
    test_single_step();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
